// File: rtl/ibex_register_file_fpga_lvt.sv
// Multi-write-port FPGA register file built on a Live Value Table.
// Each (write port, read port) pair owns a LUT-RAM bank. A flop-based table
// records which write port last wrote each word, and that entry selects the
// bank a read is served from. After reset a scrub pass loads WordZeroVal into
// every bank word. Writes are accepted only once the scrub has finished.
// Several ports writing the same word in one cycle is reported on err_o.

module ibex_register_file_fpga_lvt #(
  parameter bit                   RV32E         = 1'b0,
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          NumReadPorts  = 3,
  parameter int unsigned          NumWritePorts = 2,
  parameter bit                   WriteForward  = 1'b1,
  parameter bit                   WrenCheck     = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [5*NumReadPorts-1:0]           raddr_i,
  output logic [DataWidth*NumReadPorts-1:0]   rdata_o,
  input  logic [5*NumWritePorts-1:0]          waddr_i,
  input  logic [DataWidth*NumWritePorts-1:0]  wdata_i,
  input  logic [NumWritePorts-1:0]            we_i,
  output logic                                init_busy_o,
  output logic                                err_o
);

  localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;
  localparam int unsigned NUM_WORDS  = 1 << ADDR_WIDTH;
  localparam int unsigned LVT_WIDTH  = (NumWritePorts > 1) ? $clog2(NumWritePorts) : 1;

  typedef enum logic [0:0] {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Control and status state
  state_e                state_r;
  logic [ADDR_WIDTH-1:0] scrub_cnt_r;
  logic                  init_busy_r;
  logic                  err_r;

  // Live value table and the RAM banks, indexed [write port][read port][word]
  logic [LVT_WIDTH-1:0]  lvt_r [NUM_WORDS];
  logic [DataWidth-1:0]  mem_r [NumWritePorts][NumReadPorts][NUM_WORDS];

  // Decoded write side
  logic [ADDR_WIDTH-1:0] waddr_s      [NumWritePorts];
  logic [DataWidth-1:0]  wdata_s      [NumWritePorts];
  logic [NumWritePorts-1:0] eff_s;
  logic [NumWritePorts-1:0] win_s;
  logic [NumWritePorts-1:0] bank_we_s;
  logic [NumWritePorts-1:0] allowed_we_s;
  logic [ADDR_WIDTH-1:0] bank_addr_s  [NumWritePorts];
  logic [DataWidth-1:0]  bank_wdata_s [NumWritePorts];
  logic                  hit_s;
  logic                  collision_s;
  logic                  spurious_s;
  logic                  err_next_s;

  // Decoded read side
  logic [ADDR_WIDTH-1:0] ra_s [NumReadPorts];
  logic [DataWidth-1:0]  rd_s [NumReadPorts];

  // Slice the flat write buses into per-port address/data. Upper address bits
  // beyond ADDR_WIDTH are dropped, so x17 aliases x1 in RV32E mode.
  always_comb begin
    for (int w = 0; w < NumWritePorts; w++) begin
      waddr_s[w] = waddr_i[5*w +: ADDR_WIDTH];
      wdata_s[w] = wdata_i[DataWidth*w +: DataWidth];
    end
  end

  // A write port is effective only in RUN, when enabled, and when it does not target x0
  always_comb begin
    for (int w = 0; w < NumWritePorts; w++) begin
      eff_s[w] = we_i[w] & (waddr_s[w] != {ADDR_WIDTH{1'b0}}) & (state_r == RUN);
    end
  end

  // Resolve same-address writes: any higher-index effective port suppresses lower ones
  always_comb begin
    win_s       = eff_s;
    collision_s = 1'b0;
    hit_s       = 1'b0;
    for (int w = 0; w < NumWritePorts; w++) begin
      for (int v = w + 1; v < NumWritePorts; v++) begin
        hit_s       = eff_s[w] & eff_s[v] & (waddr_s[w] == waddr_s[v]);
        win_s[w]    = win_s[w] & ~hit_s;
        collision_s = collision_s | hit_s;
      end
    end
  end

  // Bank write controls: the scrub drives every bank, otherwise each winning port drives its own banks
  always_comb begin
    for (int w = 0; w < NumWritePorts; w++) begin
      if (state_r == SCRUB) begin
        bank_we_s[w]    = 1'b1;
        bank_addr_s[w]  = scrub_cnt_r;
        bank_wdata_s[w] = WordZeroVal;
        allowed_we_s[w] = 1'b1;
      end else begin
        bank_we_s[w]    = win_s[w];
        bank_addr_s[w]  = waddr_s[w];
        bank_wdata_s[w] = wdata_s[w];
        allowed_we_s[w] = we_i[w];
      end
    end
  end

  // Error sources: collisions, and optionally a bank write enable that nothing requested
  always_comb begin
    spurious_s = |(bank_we_s & ~allowed_we_s);
    err_next_s = collision_s | (WrenCheck & spurious_s);
  end

  // Read address decode
  always_comb begin
    for (int p = 0; p < NumReadPorts; p++) begin
      ra_s[p] = raddr_i[5*p +: ADDR_WIDTH];
    end
  end

  // Read mux: x0 and reads during the scrub give WordZeroVal. Otherwise the LVT
  // picks the bank. An optional bypass returns this cycle's write data; a
  // higher-index port wins the bypass.
  always_comb begin
    for (int p = 0; p < NumReadPorts; p++) begin
      if ((state_r == SCRUB) || (ra_s[p] == {ADDR_WIDTH{1'b0}})) begin
        rd_s[p] = WordZeroVal;
      end else begin
        rd_s[p] = mem_r[lvt_r[ra_s[p]]][p][ra_s[p]];
        for (int w = 0; w < NumWritePorts; w++) begin
          rd_s[p] = (WriteForward && eff_s[w] && (waddr_s[w] == ra_s[p])) ? wdata_s[w] : rd_s[p];
        end
      end
    end
  end

  // Pack per-port read data onto the flat output bus
  always_comb begin
    rdata_o = {(DataWidth*NumReadPorts){1'b0}};
    for (int p = 0; p < NumReadPorts; p++) begin
      rdata_o[DataWidth*p +: DataWidth] = rd_s[p];
    end
  end

  // Scrub/run sequencer with registered busy flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= SCRUB;
      scrub_cnt_r <= {ADDR_WIDTH{1'b0}};
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        SCRUB: begin
          scrub_cnt_r <= scrub_cnt_r + ADDR_WIDTH'(1);
          if (scrub_cnt_r == ADDR_WIDTH'(NUM_WORDS - 1)) begin
            state_r     <= RUN;
            init_busy_r <= 1'b0;
          end else begin
            state_r     <= SCRUB;
            init_busy_r <= 1'b1;
          end
        end
        RUN: begin
          state_r     <= RUN;
          init_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= SCRUB;
          scrub_cnt_r <= {ADDR_WIDTH{1'b0}};
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  // Error flag: one-cycle registered pulse per offending cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_next_s;
    end
  end

  // Live value table: record the winning write port for each written word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        lvt_r[i] <= {LVT_WIDTH{1'b0}};
      end
    end else begin
      for (int w = 0; w < NumWritePorts; w++) begin
        if (win_s[w]) begin
          lvt_r[waddr_s[w]] <= LVT_WIDTH'(w);
        end
      end
    end
  end

  // LUT-RAM banks: no reset, each write port updates all of its read-port copies
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < NumWritePorts; w++) begin
      for (int p = 0; p < NumReadPorts; p++) begin
        if (bank_we_s[w]) begin
          mem_r[w][p][bank_addr_s[w]] <= bank_wdata_s[w];
        end
      end
    end
  end

  assign init_busy_o = init_busy_r;
  assign err_o       = err_r;

endmodule

// File: doc/ibex_register_file_fpga_lvt.md
Name: ibex_register_file_fpga_lvt

Overview:
- Multi-write-port FPGA register file for dual-issue and writeback-merge configurations.
- Uses a Live Value Table (LVT): one LUT-RAM bank per (write port, read port) pair, plus a flop-based table recording which write port last wrote each word.
- Adds a post-reset scrub state machine that loads WordZeroVal into every bank word, plus write-collision detection.
- Sits in the ID stage in place of the single-write-port FPGA register file.

Parameters:
- RV32E, 0, 1 selects 16 words (4-bit index); 0 selects 32 words.
- DataWidth, 32, word width in bits.
- NumReadPorts, 3, number of asynchronous read ports (1..4).
- NumWritePorts, 2, number of synchronous write ports (1..4).
- WriteForward, 1, 1 means a read of an address being written this cycle returns the new write data.
- WrenCheck, 0, 1 enables spurious write-enable detection on err_o.
- WordZeroVal, '0, value loaded into every word by the scrub; also the read value of register 0.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous active-high reset.
- raddr_i  in  5*NumReadPorts  read addresses; port p uses bits [5p+4:5p].
- rdata_o  out  DataWidth*NumReadPorts  read data; port p uses bits [DataWidth*(p+1)-1:DataWidth*p].
- waddr_i  in  5*NumWritePorts  write addresses.
- wdata_i  in  DataWidth*NumWritePorts  write data.
- we_i  in  NumWritePorts  per-port write enables.
- init_busy_o  out  1  high while the scrub is running; writes are ignored while high.
- err_o  out  1  registered error flag.

Behaviour:
- Reset (asserted asynchronously)
  - FSM enters SCRUB; scrub counter = 0; all LVT entries = 0.
  - init_busy_o = 1, err_o = 0.
  - RAM contents are not reset.
- FSM states: SCRUB and RUN.
  - SCRUB: each cycle, write WordZeroVal at the counter address into every bank; increment the counter.
  - After address NUM_WORDS-1 has been written, go to RUN on the next edge. The scrub takes exactly NUM_WORDS cycles: 32, or 16 when RV32E.
  - RUN is terminal until the next reset.
  - Reset asserted mid-scrub or mid-run restarts SCRUB from address 0.
- Address width
  - Only the low ADDR_WIDTH bits of each address are used (4 bits when RV32E, else 5).
  - When RV32E, address bit 4 is ignored.
- Reads (combinational, zero latency)
  - Address 0 returns WordZeroVal.
  - While init_busy_o = 1, every read port returns WordZeroVal.
  - Otherwise, read port p returns bank[LVT[a]][p][a].
- Writes (RUN only)
  - A port w is effective when we_i[w] = 1 and its address is non-zero.
  - On the edge: every bank[w][*] is written at waddr_w, and LVT[waddr_w] is set to w.
- Collisions
  - If two or more effective ports target the same address, the highest-index port wins: its data is written and the LVT records it.
  - Lower-index ports are suppressed for that address.
  - A collision sets err_o for one cycle (registered, visible the cycle after the write edge).
- Forwarding
  - With WriteForward=1, a read of a non-zero address that matches an effective write this cycle returns that port's wdata combinationally. The highest-index matching port wins.
  - With WriteForward=0, the new value is visible from the cycle after the edge.
- WrenCheck=1
  - err_o also asserts (registered) if any internal bank write enable is high while the corresponding we_i is low, or while SCRUB is not writing.
- err_o
  - Equals the registered OR of all error sources; it is cleared each cycle unless a source is active again.
- Write to address 0: ignored, no error.
- LVT entry width: clog2(NumWritePorts); minimum 1 bit; LVT is unused when NumWritePorts = 1.

Test Plan:
1. Reset, then release rst_i; read x5 on every port -> init_busy_o stays 1 for exactly 32 cycles; rdata = WordZeroVal throughout, and still WordZeroVal after busy drops.
2. RUN: port0 writes x3 = 0x11111111; the next cycle port1 writes x3 = 0x22222222 -> read ports 0..2 return 0x22222222; later x4 written only by port0 reads back from bank 0.
3. Same cycle: port0 writes x7 = 0xAAAA0000 and port1 writes x7 = 0x5555FFFF -> x7 reads 0x5555FFFF; err_o = 1 for exactly one cycle.
4. WriteForward=1: write x9 = 0xDEADBEEF while reading x9 in the same cycle -> rdata = 0xDEADBEEF combinationally. WriteForward=0 -> old value this cycle, new value the next cycle.
5. Assert rst_i at scrub address 10, and again after writing x1 = 0x1234 in RUN -> the scrub restarts at 0 with 32 busy cycles; x1 then reads WordZeroVal.
6. RV32E=1: write x17 (5'b10001) = 0xCAFE -> aliases to x1, and x1 reads 0xCAFE. Write x0 = 0xFFFFFFFF -> x0 reads WordZeroVal and err_o stays 0.
